// File: rtl/exec_mul_sequencer_if.sv
// Execute <-> multiply sequencer handshake. Execute drives the master side;
// the sequencer sits on the slave side.
interface exec_mul_sequencer_if;
    logic        startIn;
    logic        signedIn;
    logic [63:0] operand1In;
    logic [63:0] operand2In;
    logic        killIn;
    logic        wbStallIn;
    logic        busyOut;
    logic        resultValidOut;
    logic [63:0] resultLowOut;
    logic [63:0] resultHighOut;

    modport master (
        output startIn, signedIn, operand1In, operand2In, killIn, wbStallIn,
        input  busyOut, resultValidOut, resultLowOut, resultHighOut
    );

    modport slave (
        input  startIn, signedIn, operand1In, operand2In, killIn, wbStallIn,
        output busyOut, resultValidOut, resultLowOut, resultHighOut
    );
endinterface

// File: rtl/exec_mul_sequencer.sv
// Iterative 64x64->128 shift-add multiplier for Execute (MUL/IMUL).
// Sign-magnitude: multiply magnitudes, negate the 128-bit product at the end.
module exec_mul_sequencer #(
    parameter int BITS_PER_STEP = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    exec_mul_sequencer_if.slave    bus
);
    localparam int N  = 64 / BITS_PER_STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 64 + BITS_PER_STEP;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e         state_q, state_d;
    logic [63:0]    mcand_q, mcand_d;
    logic [63:0]    mplier_q, mplier_d;
    logic [127:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [63:0]    res_lo_q, res_lo_d;
    logic [63:0]    res_hi_q, res_hi_d;

    logic [PW-1:0]  pp;
    logic [6:0]     shamt;
    logic [127:0]   acc_sum;
    logic [127:0]   fin;
    logic           last;

    // Operand bit 0 in Execute's numbering is the MSB, i.e. bit 63 here.
    function automatic logic [63:0] mag(input logic [63:0] x, input logic sgn);
        return (sgn && x[63]) ? (~x + 64'd1) : x;
    endfunction

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;

        pp      = {{BITS_PER_STEP{1'b0}}, mcand_q} *
                  {{64{1'b0}}, mplier_q[BITS_PER_STEP-1:0]};
        shamt   = 7'(cnt_q * BITS_PER_STEP);
        acc_sum = acc_q + ({{(128-PW){1'b0}}, pp} << shamt);
        fin     = neg_q ? (~acc_sum + 128'd1) : acc_sum;
        last    = (cnt_q == CW'(N - 1));

        // Kill wins over everything, including a start and a final step.
        if (bus.killIn) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.startIn) begin
                        state_d  = BUSY;
                        mcand_d  = mag(bus.operand1In, bus.signedIn);
                        mplier_d = mag(bus.operand2In, bus.signedIn);
                        neg_d    = bus.signedIn & (bus.operand1In[63] ^ bus.operand2In[63]);
                        acc_d    = '0;
                        cnt_d    = '0;
                    end
                end
                BUSY: begin
                    acc_d    = acc_sum;
                    mplier_d = mplier_q >> BITS_PER_STEP;
                    cnt_d    = cnt_q + CW'(1);
                    if (last) begin
                        state_d  = DONE;
                        res_lo_d = fin[63:0];
                        res_hi_d = fin[127:64];
                    end
                end
                DONE: begin
                    if (!bus.wbStallIn) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign bus.busyOut        = (state_q != IDLE);
    assign bus.resultValidOut = (state_q == DONE);
    assign bus.resultLowOut   = res_lo_q;
    assign bus.resultHighOut  = res_hi_q;
endmodule

// File: tb/tb_exec_mul_sequencer.sv
// Directed bench for exec_mul_sequencer: stimulus pushes expected products,
// an independent monitor pops them when a result is presented.
module tb_exec_mul_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [63:0] last_lo = '0;
    logic [63:0] last_hi = '0;

    exec_mul_sequencer_if bus();

    exec_mul_sequencer #(.BITS_PER_STEP(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller must be just after a rising edge with the DUT idle.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic push, input logic [63:0] elo, input logic [63:0] ehi);
        exp_t e;
        bus.operand1In = a;
        bus.operand2In = b;
        bus.signedIn   = s;
        bus.startIn    = 1'b1;
        if (push) begin
            e.lo = elo; e.hi = ehi; e.due = cyc + 9;
            q.push_back(e);
            last_lo = elo;
            last_hi = ehi;
        end
        step();
        bus.startIn = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busyOut && n < 64) begin
            step();
            n++;
        end
        chk("idle_timeout", 128'(bus.busyOut), 128'd0);
    endtask

    // Monitor: one expected entry per rising edge of resultValidOut; held data
    // is compared against the same entry on every stalled cycle.
    initial begin
        exp_t cur;
        logic prev = 1'b0;
        cur.lo = '0; cur.hi = '0; cur.due = 0;
        forever begin
            @(negedge clk);
            if (bus.resultValidOut) begin
                if (!prev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 128'd1, 128'd0);
                    end else begin
                        cur = q.pop_front();
                        chk("valid_cycle", 128'(cyc), 128'(cur.due));
                    end
                end
                chk("result_low", 128'(bus.resultLowOut), 128'(cur.lo));
                chk("result_high", 128'(bus.resultHighOut), 128'(cur.hi));
            end
            prev = bus.resultValidOut;
        end
    end

    initial begin
        int c0;
        bus.startIn = 1'b0; bus.signedIn = 1'b0; bus.killIn = 1'b0; bus.wbStallIn = 1'b0;
        bus.operand1In = '0; bus.operand2In = '0;
        repeat (2) step();
        chk("rst_busy", 128'(bus.busyOut), 128'd0);
        chk("rst_valid", 128'(bus.resultValidOut), 128'd0);
        chk("rst_low", 128'(bus.resultLowOut), 128'd0);
        chk("rst_high", 128'(bus.resultHighOut), 128'd0);
        reset_n = 1'b1;
        step();

        // Basic products, unsigned and signed
        issue(64'd3, 64'd5, 1'b0, 1'b1, 64'hF, 64'h0); wait_idle();
        issue('1, '1, 1'b0, 1'b1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE); wait_idle();
        issue(-64'sd2, 64'd3, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, '1); wait_idle();
        issue(64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h0); wait_idle();
        issue(64'h8000_0000_0000_0000, 64'd2, 1'b0, 1'b1, 64'h0, 64'h1); wait_idle();
        issue(64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b1, 64'h0, '1); wait_idle();
        issue(64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1'b1, 64'h0, 64'h1); wait_idle();
        issue(64'd0, -64'sd5, 1'b1, 1'b1, 64'h0, 64'h0); wait_idle();
        issue('1, '1, 1'b1, 1'b1, 64'h1, 64'h0); wait_idle();
        issue(64'h1234_5678_9ABC_DEF0, 64'h10, 1'b0, 1'b1, 64'h2345_6789_ABCD_EF00, 64'h1); wait_idle();

        // startIn held through BUSY with other operands is ignored
        issue(64'd7, 64'd9, 1'b0, 1'b1, 64'h3F, 64'h0);
        bus.operand1In = 64'd100; bus.operand2In = 64'd100; bus.startIn = 1'b1;
        repeat (8) step();
        bus.startIn = 1'b0;
        wait_idle();

        // Writeback stall holds the result, then a new start right at IDLE
        c0 = cyc;
        issue(64'd7, 64'd6, 1'b0, 1'b1, 64'h2A, 64'h0);
        bus.wbStallIn = 1'b1;
        repeat (12) step();
        chk("stall_cycle13", 128'(cyc - c0), 128'd13);
        bus.wbStallIn = 1'b0;
        chk("stall_valid13", 128'(bus.resultValidOut), 128'd1);
        step();
        chk("stall_idle14", 128'(bus.busyOut), 128'd0);
        issue(64'h1234_5678_9ABC_DEF0, 64'h10, 1'b1, 1'b1, 64'h2345_6789_ABCD_EF00, 64'h1);
        wait_idle();

        // Kill mid-operation: no result, result registers keep last value
        issue(64'd11, 64'd13, 1'b0, 1'b0, '0, '0);
        repeat (3) step();
        bus.killIn = 1'b1;
        step();
        bus.killIn = 1'b0;
        chk("kill_busy", 128'(bus.busyOut), 128'd0);
        chk("kill_valid", 128'(bus.resultValidOut), 128'd0);
        chk("kill_low", 128'(bus.resultLowOut), 128'(last_lo));
        chk("kill_high", 128'(bus.resultHighOut), 128'(last_hi));
        for (int i = 0; i < 12; i++) begin
            step();
            chk("kill_no_valid", 128'(bus.resultValidOut), 128'd0);
        end

        // Kill together with start in IDLE: start is dropped
        bus.operand1In = 64'd2; bus.operand2In = 64'd2; bus.startIn = 1'b1; bus.killIn = 1'b1;
        step();
        bus.startIn = 1'b0; bus.killIn = 1'b0;
        chk("kill_start_busy", 128'(bus.busyOut), 128'd0);
        repeat (10) step();
        chk("kill_start_valid", 128'(bus.resultValidOut), 128'd0);

        // Reset mid-operation
        issue(64'd11, 64'd13, 1'b0, 1'b0, '0, '0);
        repeat (3) step();
        reset_n = 1'b0;
        step();
        chk("rstmid_busy", 128'(bus.busyOut), 128'd0);
        chk("rstmid_valid", 128'(bus.resultValidOut), 128'd0);
        chk("rstmid_low", 128'(bus.resultLowOut), 128'd0);
        chk("rstmid_high", 128'(bus.resultHighOut), 128'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rstmid_no_valid", 128'(bus.resultValidOut), 128'd0);
        end

        // Engine still works after reset
        issue(-64'sd3, -64'sd5, 1'b1, 1'b1, 64'hF, 64'h0);
        wait_idle();
        repeat (3) step();
        chk("queue_drained", 128'(q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
